reg_write_bank: RTL and testbench

- Write side of the 32-entry, 32-bit register file.
- Decodes a 5-bit write address into a one-hot enable and stores write data into the selected register on the clock edge.
- Presents all 32 register contents continuously as r0..r31, which feed directly into the existing 32:1 read-select mux.
- Also provides a one-cycle write acknowledge and a sticky per-register "written" mask for debug and verification.

---
 rtl/reg_write_bank.sv | 124 ++++++++++++
 tb/tb_reg_write_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_bank.sv
// rtl/reg_write_bank.sv - write side of the 32x32 register file
// One-hot write decode, flop storage per register, write acknowledge and sticky written mask.
module reg_write_bank #(
  parameter int DATA_W  = 32,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        ws,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15,
  output logic [DATA_W-1:0] r16,
  output logic [DATA_W-1:0] r17,
  output logic [DATA_W-1:0] r18,
  output logic [DATA_W-1:0] r19,
  output logic [DATA_W-1:0] r20,
  output logic [DATA_W-1:0] r21,
  output logic [DATA_W-1:0] r22,
  output logic [DATA_W-1:0] r23,
  output logic [DATA_W-1:0] r24,
  output logic [DATA_W-1:0] r25,
  output logic [DATA_W-1:0] r26,
  output logic [DATA_W-1:0] r27,
  output logic [DATA_W-1:0] r28,
  output logic [DATA_W-1:0] r29,
  output logic [DATA_W-1:0] r30,
  output logic [DATA_W-1:0] r31,
  output logic [31:0]       wsel,
  output logic              wr_ack,
  output logic [31:0]       wr_mask
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [31:0]       wr_mask_q, wr_mask_d;
  logic              wr_ack_q, wr_ack_d;
  logic [31:0]       wen;

  // Compare-based decode: an unknown we or ws fails every if, so no enable fires.
  always_comb begin
    wsel = '0;
    if (we) begin
      for (int i = 0; i < 32; i++) begin
        if (ws == 5'(i)) wsel[i] = 1'b1;
      end
    end
  end

  assign wen = wsel & ~{31'b0, R0_ZERO};

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 32; i++) begin
      if (wen[i]) regs_d[i] = wd;
    end
    wr_ack_d  = |wen;
    wr_mask_d = wr_mask_q | wen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      wr_ack_q  <= 1'b0;
      wr_mask_q <= '0;
    end else begin
      regs_q    <= regs_d;
      wr_ack_q  <= wr_ack_d;
      wr_mask_q <= wr_mask_d;
    end
  end

  assign wr_ack  = wr_ack_q;
  assign wr_mask = wr_mask_q;

  assign r0  = regs_q[0];
  assign r1  = regs_q[1];
  assign r2  = regs_q[2];
  assign r3  = regs_q[3];
  assign r4  = regs_q[4];
  assign r5  = regs_q[5];
  assign r6  = regs_q[6];
  assign r7  = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];
  assign r15 = regs_q[15];
  assign r16 = regs_q[16];
  assign r17 = regs_q[17];
  assign r18 = regs_q[18];
  assign r19 = regs_q[19];
  assign r20 = regs_q[20];
  assign r21 = regs_q[21];
  assign r22 = regs_q[22];
  assign r23 = regs_q[23];
  assign r24 = regs_q[24];
  assign r25 = regs_q[25];
  assign r26 = regs_q[26];
  assign r27 = regs_q[27];
  assign r28 = regs_q[28];
  assign r29 = regs_q[29];
  assign r30 = regs_q[30];
  assign r31 = regs_q[31];

endmodule

// File: tb/tb_reg_write_bank.sv
// tb/tb_reg_write_bank.sv - self-checking bench for reg_write_bank
// Runs R0_ZERO=1 and R0_ZERO=0 instances side by side against one reference model.
module tb_reg_write_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  ws;
  logic [31:0] wd;

  logic [31:0] rz [32];
  logic [31:0] rn [32];
  logic [31:0] wsel_z, wsel_n, mask_z, mask_n;
  logic        ack_z, ack_n;

  int checks = 0;
  int errors = 0;

  // Model index 0 tracks the R0_ZERO=1 instance, index 1 the R0_ZERO=0 instance.
  logic [31:0] mr [2][32];
  logic [31:0] mmask [2];
  logic        mack [2];

  always #5 clk = ~clk;

  reg_write_bank #(.DATA_W(32), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .ws(ws), .wd(wd),
    .r0(rz[0]),   .r1(rz[1]),   .r2(rz[2]),   .r3(rz[3]),   .r4(rz[4]),   .r5(rz[5]),
    .r6(rz[6]),   .r7(rz[7]),   .r8(rz[8]),   .r9(rz[9]),   .r10(rz[10]), .r11(rz[11]),
    .r12(rz[12]), .r13(rz[13]), .r14(rz[14]), .r15(rz[15]), .r16(rz[16]), .r17(rz[17]),
    .r18(rz[18]), .r19(rz[19]), .r20(rz[20]), .r21(rz[21]), .r22(rz[22]), .r23(rz[23]),
    .r24(rz[24]), .r25(rz[25]), .r26(rz[26]), .r27(rz[27]), .r28(rz[28]), .r29(rz[29]),
    .r30(rz[30]), .r31(rz[31]),
    .wsel(wsel_z), .wr_ack(ack_z), .wr_mask(mask_z)
  );

  reg_write_bank #(.DATA_W(32), .R0_ZERO(1'b0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .ws(ws), .wd(wd),
    .r0(rn[0]),   .r1(rn[1]),   .r2(rn[2]),   .r3(rn[3]),   .r4(rn[4]),   .r5(rn[5]),
    .r6(rn[6]),   .r7(rn[7]),   .r8(rn[8]),   .r9(rn[9]),   .r10(rn[10]), .r11(rn[11]),
    .r12(rn[12]), .r13(rn[13]), .r14(rn[14]), .r15(rn[15]), .r16(rn[16]), .r17(rn[17]),
    .r18(rn[18]), .r19(rn[19]), .r20(rn[20]), .r21(rn[21]), .r22(rn[22]), .r23(rn[23]),
    .r24(rn[24]), .r25(rn[25]), .r26(rn[26]), .r27(rn[27]), .r28(rn[28]), .r29(rn[29]),
    .r30(rn[30]), .r31(rn[31]),
    .wsel(wsel_n), .wr_ack(ack_n), .wr_mask(mask_n)
  );

  typedef struct {
    logic        we;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic [31:0] exp_wsel;
    logic        exp_ack_z;
    logic        exp_ack_n;
    logic [31:0] exp_mask_z;
    logic [31:0] exp_mask_n;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) mr[k][i] = '0;
      mmask[k] = '0;
      mack[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic acc;
        acc = we && !(k == 0 && ws == 5'd0);
        mack[k] = acc;
        if (acc) begin
          mr[k][ws]    = wd;
          mmask[k][ws] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s z_r%0d", tag, i), rz[i], mr[0][i]);
      chk($sformatf("%s n_r%0d", tag, i), rn[i], mr[1][i]);
    end
    chk({tag, " z_mask"}, mask_z, mmask[0]);
    chk({tag, " n_mask"}, mask_n, mmask[1]);
    chk({tag, " z_ack"}, {31'b0, ack_z}, {31'b0, mack[0]});
    chk({tag, " n_ack"}, {31'b0, ack_n}, {31'b0, mack[1]});
  endtask

  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic r, input string tag);
    logic [31:0] exp_sel;
    @(negedge clk);
    rst = r; we = w; ws = a; wd = d;
    #1;
    exp_sel = w ? (32'd1 << a) : 32'd0;
    chk({tag, " wsel_z"}, wsel_z, exp_sel);
    chk({tag, " wsel_n"}, wsel_n, exp_sel);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b0; ws = '0; wd = '0;
    model_reset();
    #2;
    check_all("reset");

    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{1'b1, 5'd7,  32'hDEAD_BEEF, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0080};
    vecs[1] = '{1'b0, 5'd7,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0080};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0081};
    vecs[3] = '{1'b1, 5'd31, 32'h0000_000A, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0080, 32'h8000_0081};
    vecs[4] = '{1'b1, 5'd31, 32'h0000_000B, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0080, 32'h8000_0081};
    vecs[5] = '{1'b1, 5'd1,  32'h0000_000C, 32'h0000_0002, 1'b1, 1'b1, 32'h8000_0082, 32'h8000_0083};
    vecs[6] = '{1'b0, 5'd1,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h8000_0082, 32'h8000_0083};

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      we = vecs[v].we; ws = vecs[v].ws; wd = vecs[v].wd;
      #1;
      chk($sformatf("vec%0d wsel", v), wsel_z, vecs[v].exp_wsel);
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("vec%0d ack_z", v), {31'b0, ack_z}, {31'b0, vecs[v].exp_ack_z});
      chk($sformatf("vec%0d ack_n", v), {31'b0, ack_n}, {31'b0, vecs[v].exp_ack_n});
      chk($sformatf("vec%0d mask_z", v), mask_z, vecs[v].exp_mask_z);
      chk($sformatf("vec%0d mask_n", v), mask_n, vecs[v].exp_mask_n);
      check_all($sformatf("vec%0d", v));
    end
    chk("table r7", rz[7], 32'hDEAD_BEEF);
    chk("table z_r0", rz[0], 32'h0);
    chk("table n_r0", rn[0], 32'hFFFF_FFFF);
    chk("table r31", rz[31], 32'h0000_000B);
    chk("table r1", rz[1], 32'h0000_000C);

    // Asynchronous reset lands between edges, right after an acknowledged write.
    step(1'b1, 5'd5, 32'h1234_5678, 1'b0, "pre_async");
    chk("pre_async r5", rz[5], 32'h1234_5678);
    @(negedge clk);
    we = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async r5", rz[5], 32'h0);
    chk("async mask", mask_z, 32'h0);
    chk("async ack", {31'b0, ack_z}, 32'h0);
    check_all("async");

    step(1'b1, 5'd3, 32'h55, 1'b1, "rst_vs_wr");
    chk("rst_vs_wr r3", rz[3], 32'h0);
    chk("rst_vs_wr ack", {31'b0, ack_n}, 32'h0);
    step(1'b0, 5'd3, 32'h55, 1'b0, "rst_release");

    for (int n = 1; n < 32; n++) begin
      step(1'b1, 5'(n), 32'(n) * 32'h0101_0101, 1'b0, $sformatf("sweep%0d", n));
    end
    for (int n = 1; n < 32; n++) begin
      chk($sformatf("sweep r%0d", n), rz[n], 32'(n) * 32'h0101_0101);
    end
    chk("sweep mask_z", mask_z, 32'hFFFF_FFFE);
    chk("sweep mask_n", mask_n, 32'hFFFF_FFFE);

    for (int t = 0; t < 400; t++) begin
      logic        w, r;
      logic [4:0]  a;
      logic [31:0] d;
      w = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      d = $urandom;
      r = ($urandom_range(0, 49) == 0);
      step(w, a, d, r, $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
